mod53_inv_const_mul_seq: RTL

- Sequential inverse of the mod-53 constant-multiply lookup blocks in the x_500 set. The forward LUT block maps a residue r to (r*23) mod 53.
- This block returns z = (x * C_INV) mod 53 with C_INV = 23^-1 mod 53 = 30, so a forward-mapped residue decodes back to its source.
- Method: serial MSB-first double-and-add over the 6 constant bits.
- Handshake: valid/ready on both sides, so it sits between residue-channel pipeline stages.

---
 rtl/mod53_inv_const_mul_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mod53_inv_const_mul_seq.sv
// mod53_inv_const_mul_seq
//
// Computes z = (x * C_INV) mod 53 with a serial MSB-first double-and-add over
// the six bits of C_INV. With the default C_INV = 30 (the inverse of 23 mod 53)
// this undoes the forward residue mapping r -> (r*23) mod 53.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Input: x is taken on an edge with
// in_valid & in_ready; in_ready is high only in IDLE. Output: z/range_err
// are valid while out_valid is high (DONE) and stay stable until an edge
// with out_ready high, which returns the block to IDLE. No output depends
// combinationally on in_valid or out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input residue valid
//   in_ready   block can accept input (state == IDLE)
//   x [5:0]    input residue; 53..63 are out of range and reduced by 53
//   out_valid  result valid (state == DONE)
//   out_ready  downstream accepts result
//   z [5:0]    result residue, always 0..52
//   range_err  accepted x was >= 53; qualified by out_valid
//   busy       high in CALC or DONE
//   dbg_state  current FSM state, for observation only
module mod53_inv_const_mul_seq #(
  // Constant multiplier, must be in 0..52.
  parameter int unsigned C_INV = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] x,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] z,
  output logic       range_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widened so any 3-bit counter value is a legal bit index.
  localparam logic [7:0] C_EXT = 8'(C_INV);
  localparam logic [6:0] MOD7  = 7'd53;
  localparam logic [5:0] MOD6  = 6'd53;

  state_t     state, state_next;
  logic [5:0] acc, acc_next;
  logic [5:0] xr, xr_next;
  logic [2:0] cnt, cnt_next;
  logic [5:0] z_next;
  logic       err_next;
  logic [6:0] t, u;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      xr        <= '0;
      cnt       <= '0;
      z         <= '0;
      range_err <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      xr        <= xr_next;
      cnt       <= cnt_next;
      z         <= z_next;
      range_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    xr_next    = xr;
    cnt_next   = cnt;
    z_next     = z;
    err_next   = range_err;
    t          = '0;
    u          = '0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          // x is at most 63, so one conditional subtract gives 0..52.
          xr_next    = (x >= MOD6) ? x - MOD6 : x;
          err_next   = (x >= MOD6);
          acc_next   = '0;
          cnt_next   = 3'd5;
          state_next = CALC;
        end
      end

      CALC: begin
        // acc and xr are both < 53, so 7 bits hold 2*acc and t + xr.
        t = {acc, 1'b0};
        if (t >= MOD7) t = t - MOD7;
        u = t;
        if (C_EXT[cnt]) begin
          u = t + {1'b0, xr};
          if (u >= MOD7) u = u - MOD7;
        end
        acc_next = u[5:0];
        if (cnt == 3'd0) begin
          z_next     = u[5:0];
          state_next = DONE;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end

      DONE: begin
        if (out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
